// File: rtl/fpu_pkg.sv
// Shared widths and types for the shared barrel-shift arbiter.
// Only the 32-bit configuration is supported.
package fpu_pkg;

  localparam int DATA_W  = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  typedef logic req_id_t;

  localparam req_id_t REQ0 = 1'b0;
  localparam req_id_t REQ1 = 1'b1;

  function automatic req_id_t other_id(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational logical barrel shifter, zero fill in both directions.
// Left shifts reuse the right-shift network by bit-reversing input and output.
module barrel_shifter #(
  parameter int DATA_W  = fpu_pkg::DATA_W,
  parameter int SHAMT_W = fpu_pkg::SHAMT_W
) (
  input  logic [DATA_W-1:0]  a,
  input  logic [SHAMT_W-1:0] shift_amount,
  input  logic               left,
  output logic [DATA_W-1:0]  res
);

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] stage_s;

  // Log-depth right-shift stages, one per shift-amount bit.
  always_comb begin
    if (left) begin
      stage_s = bit_rev(a);
    end else begin
      stage_s = a;
    end
    for (int s = 0; s < SHAMT_W; s++) begin
      if (shift_amount[s]) begin
        stage_s = stage_s >> (1 << s);
      end else begin
        stage_s = stage_s;
      end
    end
    if (left) begin
      res = bit_rev(stage_s);
    end else begin
      res = stage_s;
    end
  end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Two requesters share one barrel shifter through a round-robin grant and a
// one-entry registered result tagged with its owner.
module barrel_shift_arbiter #(
  parameter int DATA_W  = fpu_pkg::DATA_W,
  parameter int SHAMT_W = fpu_pkg::SHAMT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_left,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_left,
  output logic               rsp0_valid,
  input  logic               rsp0_ready,
  output logic               rsp1_valid,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp_res
);

  import fpu_pkg::*;

  state_t             state_r, next_state_s;
  req_id_t            owner_r, next_owner_s;
  req_id_t            ptr_r, next_ptr_s;
  logic [DATA_W-1:0]  res_r, next_res_s;
  logic [1:0]         rsp_valid_r, next_rsp_valid_s;
  logic               owner_ready_s, can_grant_s, grant0_s, grant1_s, load_s;
  logic [DATA_W-1:0]  shift_a_s, shift_res_s;
  logic [SHAMT_W-1:0] shift_amt_s;
  logic               shift_left_s;

  // Grant decision and operand mux; a held result frees the slot when its owner consumes it.
  always_comb begin
    if (owner_r == REQ1) begin
      owner_ready_s = rsp1_ready;
    end else begin
      owner_ready_s = rsp0_ready;
    end
    can_grant_s = (state_r == EMPTY) || owner_ready_s;
    grant0_s    = can_grant_s && req0_valid && (!req1_valid || (ptr_r == REQ0));
    grant1_s    = can_grant_s && req1_valid && (!req0_valid || (ptr_r == REQ1));
    load_s      = grant0_s || grant1_s;
    if (grant1_s) begin
      shift_a_s    = req1_a;
      shift_amt_s  = req1_shamt;
      shift_left_s = req1_left;
    end else begin
      shift_a_s    = req0_a;
      shift_amt_s  = req0_shamt;
      shift_left_s = req0_left;
    end
  end

  barrel_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .a            (shift_a_s),
    .shift_amount (shift_amt_s),
    .left         (shift_left_s),
    .res          (shift_res_s)
  );

  // Next-state logic for the result slot, owner tag and priority pointer.
  always_comb begin
    next_state_s     = state_r;
    next_owner_s     = owner_r;
    next_ptr_s       = ptr_r;
    next_res_s       = res_r;
    next_rsp_valid_s = rsp_valid_r;
    if (load_s) begin
      next_owner_s     = grant1_s ? REQ1 : REQ0;
      next_ptr_s       = other_id(grant1_s ? REQ1 : REQ0);
      next_res_s       = shift_res_s;
      next_rsp_valid_s = grant1_s ? 2'b10 : 2'b01;
    end else begin
      next_ptr_s = ptr_r;
    end
    case (state_r)
      EMPTY: begin
        if (load_s) begin
          next_state_s = FULL;
        end else begin
          next_state_s = EMPTY;
        end
      end
      FULL: begin
        if (load_s) begin
          next_state_s = FULL;
        end else if (owner_ready_s) begin
          next_state_s     = EMPTY;
          next_rsp_valid_s = 2'b00;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s     = EMPTY;
        next_rsp_valid_s = 2'b00;
      end
    endcase
  end

  // State register; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      owner_r     <= REQ0;
      ptr_r       <= REQ0;
      res_r       <= '0;
      rsp_valid_r <= 2'b00;
    end else begin
      state_r     <= next_state_s;
      owner_r     <= next_owner_s;
      ptr_r       <= next_ptr_s;
      res_r       <= next_res_s;
      rsp_valid_r <= next_rsp_valid_s;
    end
  end

  assign req0_ready = grant0_s && rst_n;
  assign req1_ready = grant1_s && rst_n;
  assign rsp0_valid = rsp_valid_r[0];
  assign rsp1_valid = rsp_valid_r[1];
  assign rsp_res    = res_r;

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed and randomized checks of barrel_shift_arbiter against a
// transaction-level model of the shared result slot.
module tb_barrel_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_a [2];
  logic [4:0]  req_shamt [2];
  logic        req_left [2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] rsp_res;

  int total = 0;
  int bad   = 0;

  bit          m_held;
  int          m_owner;
  int          m_pref;
  logic [31:0] m_res;
  bit [1:0]    granted;
  int          n_ops;

  logic [31:0] t_a   [8] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h8000_0000,
                             32'h1234_5678, 32'h1234_5678, 32'h0000_FFFF, 32'hF000_0000};
  logic [4:0]  t_sh  [8] = '{5'd31, 5'd0, 5'd0, 5'd31, 5'd4, 5'd4, 5'd16, 5'd28};
  logic        t_l   [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] t_exp [8] = '{32'h8000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0001,
                             32'h2345_6780, 32'h0123_4567, 32'hFFFF_0000, 32'h0000_000F};

  barrel_shift_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req_valid[0]),
    .req0_ready (req0_ready),
    .req0_a     (req_a[0]),
    .req0_shamt (req_shamt[0]),
    .req0_left  (req_left[0]),
    .req1_valid (req_valid[1]),
    .req1_ready (req1_ready),
    .req1_a     (req_a[1]),
    .req1_shamt (req_shamt[1]),
    .req1_left  (req_left[1]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp_ready[0]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp_ready[1]),
    .rsp_res    (rsp_res)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] shift_ref(input logic [31:0] a, input int sh, input bit left);
    return left ? (a << sh) : (a >> sh);
  endfunction

  task automatic model_reset();
    m_held  = 1'b0;
    m_owner = 0;
    m_pref  = 0;
    m_res   = 32'd0;
    granted = 2'b00;
  endtask

  task automatic set_op(input int p, input logic [31:0] a, input logic [4:0] sh, input logic l);
    req_a[p]     = a;
    req_shamt[p] = sh;
    req_left[p]  = l;
  endtask

  // Observe one cycle at the falling edge, compare, then advance the model past the next rising edge.
  task automatic sample();
    bit can, g0, g1;
    int id;
    @(negedge clk);
    chk("rsp0_valid", {31'd0, rsp0_valid}, {31'd0, m_held && (m_owner == 0)});
    chk("rsp1_valid", {31'd0, rsp1_valid}, {31'd0, m_held && (m_owner == 1)});
    chk("rsp_excl", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
    if (m_held) chk("rsp_res", rsp_res, m_res);
    can = !m_held || rsp_ready[m_owner];
    g0  = can && req_valid[0] && (!req_valid[1] || m_pref == 0);
    g1  = can && req_valid[1] && (!req_valid[0] || m_pref == 1);
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    granted = {g1, g0};
    if (m_held && rsp_ready[m_owner]) m_held = 1'b0;
    if (g0 || g1) begin
      id      = g1 ? 1 : 0;
      m_held  = 1'b1;
      m_owner = id;
      m_res   = shift_ref(req_a[id], int'(req_shamt[id]), req_left[id]);
      m_pref  = 1 - id;
      n_ops++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 2'b00;
    rst_n     = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int cycles;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_op(0, 32'h1, 5'd1, 1'b1);
    set_op(1, 32'h1, 5'd1, 1'b1);
    model_reset();
    #3;
    chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
    chk("rst_rsp_res", rsp_res, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    do_reset();

    // Single op straight out of reset.
    set_op(0, 32'h0000_00F0, 5'd4, 1'b1);
    req_valid = 2'b01;
    sample();
    chk("single_ready", {31'd0, req0_ready}, 32'd1);
    advance();
    req_valid = 2'b00;
    sample();
    chk("single_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("single_res", rsp_res, 32'h0000_0F00);
    advance();

    // Round-robin under contention starts with requester 0 after reset.
    do_reset();
    set_op(0, 32'h8000_0000, 5'd31, 1'b0);
    set_op(1, 32'h8000_0000, 5'd31, 1'b0);
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("rr_g0", {31'd0, req0_ready}, {31'd0, (i % 2) == 0});
      chk("rr_g1", {31'd0, req1_ready}, {31'd0, (i % 2) == 1});
      if (i > 0) chk("rr_res", rsp_res, 32'h0000_0001);
      advance();
    end
    req_valid = 2'b00;
    sample();
    chk("rr_res_last", rsp_res, 32'h0000_0001);
    advance();

    // Backpressure on requester 1 with requester 0 waiting.
    set_op(1, 32'h1234_5678, 5'd0, 1'b0);
    req_valid = 2'b10;
    rsp_ready = 2'b01;
    sample();
    chk("bp_accept", {31'd0, req1_ready}, 32'd1);
    advance();
    set_op(0, 32'h0000_0001, 5'd1, 1'b1);
    req_valid = 2'b01;
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("bp_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("bp_res", rsp_res, 32'h1234_5678);
      chk("bp_r0", {31'd0, req0_ready}, 32'd0);
      chk("bp_r1", {31'd0, req1_ready}, 32'd0);
      advance();
    end
    rsp_ready = 2'b11;
    sample();
    chk("bp_release_grant", {31'd0, req0_ready}, 32'd1);
    advance();
    req_valid = 2'b00;
    sample();
    chk("bp_next_valid", {31'd0, rsp0_valid}, 32'd1);
    chk("bp_next_res", rsp_res, 32'h0000_0002);
    advance();

    // Eight back-to-back ops on requester 0.
    rsp_ready = 2'b01;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) begin
        set_op(0, t_a[i], t_sh[i], t_l[i]);
        req_valid = 2'b01;
      end else begin
        req_valid = 2'b00;
      end
      sample();
      if (i < 8) chk("tp_ready", {31'd0, req0_ready}, 32'd1);
      if (i > 0) begin
        chk("tp_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("tp_res", rsp_res, t_exp[i-1]);
      end
      advance();
    end

    // Reset while a result is held and not consumed.
    rsp_ready = 2'b00;
    set_op(0, 32'h0000_00FF, 5'd8, 1'b1);
    req_valid = 2'b01;
    sample();
    advance();
    chk("mid_full", {31'd0, rsp0_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
    chk("mid_rsp_res", rsp_res, 32'd0);
    chk("mid_req0_ready", {31'd0, req0_ready}, 32'd0);
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    set_op(0, 32'h0000_0003, 5'd2, 1'b1);
    set_op(1, 32'hC000_0000, 5'd30, 1'b0);
    req_valid = 2'b11;
    sample();
    chk("post_rst_g0", {31'd0, req0_ready}, 32'd1);
    chk("post_rst_g1", {31'd0, req1_ready}, 32'd0);
    advance();
    req_valid = 2'b00;
    sample();
    advance();

    // Randomized traffic on both ports.
    n_ops   = 0;
    cycles  = 0;
    granted = 2'b00;
    while (n_ops < 10000 && cycles < 60000) begin
      for (int p = 0; p < 2; p++) begin
        if (!req_valid[p] || granted[p]) begin
          if ($urandom_range(1, 0) == 1) begin
            req_valid[p] = 1'b1;
            case ($urandom_range(3, 0))
              0:       req_a[p] = 32'hFFFF_FFFF;
              1:       req_a[p] = 32'h8000_0001;
              default: req_a[p] = $urandom;
            endcase
            req_shamt[p] = 5'($urandom_range(31, 0));
            req_left[p]  = 1'($urandom_range(1, 0));
          end else begin
            req_valid[p] = 1'b0;
          end
        end
        rsp_ready[p] = ($urandom_range(3, 0) != 0);
      end
      sample();
      advance();
      cycles++;
    end
    chk("rand_op_count", {31'd0, n_ops >= 10000}, 32'd1);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    sample();
    advance();
    sample();
    chk("drain_empty", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    advance();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
